// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line levels and parity mode.
// Reused by the transmitter now and the receiver later.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP1  = 3'd5,
    STOP2  = 3'd6
  } uart_state_e;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } uart_parity_e;

  function automatic uart_parity_e parity_mode(input logic en, input logic odd);
    if (!en)
      return PAR_NONE;
    return odd ? PAR_ODD : PAR_EVEN;
  endfunction

  // data_xor is the reduction XOR of the payload; odd parity inverts it.
  function automatic logic parity_bit(input uart_parity_e mode, input logic data_xor);
    return data_xor ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Valid/ready byte hand-over into the UART transmitter.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tick.sv
// Rising-edge detector on the baud square wave; uclk is sampled as data on clk.
module uart_tick (
  input  logic clk,
  input  logic rst,
  input  logic uclk,
  output logic tick
);

  logic uclk_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      uclk_q <= 1'b0;
    else
      uclk_q <= uclk;
  end

  assign tick = uclk & ~uclk_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// state  | meaning
// IDLE   | line high, ready for a frame
// ARMED  | frame latched, waiting for the next tick to begin the start bit
// START  | start bit on the line
// DATA   | data bit idx_q on the line
// PARITY | parity bit on the line
// STOP1  | first stop bit
// STOP2  | second stop bit (only when stop2 was latched)
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      uclk,
  uart_tx_if.slave  tx,
  input  logic      par_en,
  input  logic      par_odd,
  input  logic      stop2,
  output logic      txd,
  output logic      tx_busy,
  output logic      tx_done
);

  localparam int CNT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     idx_q, idx_d;
  logic                 txd_q, txd_d;
  logic                 done_q, done_d;
  logic                 par_en_q, stop2_q, par_bit_q;
  logic                 tick;
  logic                 accept;

  uart_tick u_tick (
    .clk  (clk),
    .rst  (rst),
    .uclk (uclk),
    .tick (tick)
  );

  assign tx.tx_ready = (state_q == IDLE);
  assign accept      = tx.tx_valid & tx.tx_ready;
  assign txd         = txd_q;
  assign tx_busy     = (state_q != IDLE);
  assign tx_done     = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      txd_q   <= UART_IDLE_LEVEL;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
    end
  end

  // Frame configuration is frozen at acceptance so mid-frame changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_en_q  <= 1'b0;
      stop2_q   <= 1'b0;
      par_bit_q <= 1'b0;
    end else if (accept) begin
      par_en_q  <= par_en;
      stop2_q   <= stop2;
      par_bit_q <= parity_bit(parity_mode(par_en, par_odd), ^tx.tx_data);
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    txd_d   = txd_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        txd_d = UART_IDLE_LEVEL;
        if (accept) begin
          state_d = ARMED;
          shift_d = tx.tx_data;
        end
      end
      ARMED: begin
        if (tick) begin
          state_d = START;
          txd_d   = UART_START_LEVEL;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          idx_d   = '0;
          txd_d   = shift_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (idx_q != LAST_IDX) begin
            idx_d   = idx_q + CNT_W'(1);
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
          end else if (par_en_q) begin
            state_d = PARITY;
            txd_d   = par_bit_q;
          end else begin
            state_d = STOP1;
            txd_d   = UART_IDLE_LEVEL;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d = STOP1;
          txd_d   = UART_IDLE_LEVEL;
        end
      end
      STOP1: begin
        if (tick) begin
          if (stop2_q) begin
            state_d = STOP2;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      STOP2: begin
        if (tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = UART_IDLE_LEVEL;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed scenarios plus random frames,
// compared against a bit-list model of the serial frame.
module tb_uart_tx;

  localparam int DATA_BITS = 8;
  localparam int BIT_CLKS  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uclk = 1'b0;
  logic par_en = 1'b0;
  logic par_odd = 1'b0;
  logic stop2 = 1'b0;
  logic txd, tx_busy, tx_done;

  int n_asserts = 0;
  int n_fails   = 0;

  uart_tx_if #(.DATA_BITS(DATA_BITS)) bus ();

  uart_tx #(.DATA_BITS(DATA_BITS)) dut (
    .clk     (clk),
    .rst     (rst),
    .uclk    (uclk),
    .tx      (bus.slave),
    .par_en  (par_en),
    .par_odd (par_odd),
    .stop2   (stop2),
    .txd     (txd),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  // clk rises at 5,15,...; uclk toggles on clk falling edges, 16 clk per period.
  always #5 clk = ~clk;
  always #80 uclk = ~uclk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic pe, input logic po, input logic s2);
    @(negedge clk);
    par_en = pe; par_odd = po; stop2 = s2;
    bus.tx_data = d;
    bus.tx_valid = 1'b1;
    @(posedge clk);
    #1 bus.tx_valid = 1'b0;
  endtask

  // Model: expected line level for each bit period of the frame.
  task automatic check_frame(input logic [7:0] d, input logic pe, input logic po,
                             input logic s2, input int exp_wait, input string tag);
    bit exp_q[$];
    int w;
    int bad;
    exp_q.push_back(1'b0);
    for (int i = 0; i < DATA_BITS; i++) exp_q.push_back(d[i]);
    if (pe) exp_q.push_back((^d) ^ po);
    exp_q.push_back(1'b1);
    if (s2) exp_q.push_back(1'b1);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (txd !== 1'b0 && w < 400);
    chk({tag, " start_seen"}, txd, 1'b0);
    if (exp_wait > 0) chk({tag, " start_latency"}, w, exp_wait);
    for (int b = 0; b < exp_q.size(); b++) begin
      bad = 0;
      for (int s = 0; s < BIT_CLKS; s++) begin
        if (!(b == 0 && s == 0)) @(negedge clk);
        if (txd !== exp_q[b] || tx_done !== 1'b0 || tx_busy !== 1'b1 || bus.tx_ready !== 1'b0)
          bad++;
      end
      chk($sformatf("%s bit%0d_bad_samples", tag, b), bad, 0);
    end
    @(negedge clk);
    chk({tag, " done{done,ready,busy,txd}"}, {tx_done, bus.tx_ready, tx_busy, txd}, 4'b1101);
  endtask

  initial begin
    int bad;
    int w;
    logic [7:0] rd;
    logic rpe, rpo, rs2;

    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset{txd,ready,busy,done}", {txd, bus.tx_ready, tx_busy, tx_done}, 4'b1100);
    rst = 1'b0;

    // Idle for 100 cycles with no valid
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if ({txd, bus.tx_ready, tx_busy, tx_done} !== 4'b1100) bad++;
    end
    chk("idle_bad_samples", bad, 0);

    // Basic frame
    send(8'h55, 1'b0, 1'b0, 1'b0);
    check_frame(8'h55, 1'b0, 1'b0, 1'b0, -1, "basic55");
    @(negedge clk);
    chk("basic55 done_one_cycle", tx_done, 1'b0);

    // Parity with two stop bits
    send(8'hA3, 1'b1, 1'b0, 1'b1);
    check_frame(8'hA3, 1'b1, 1'b0, 1'b1, -1, "a3_even_s2");
    send(8'hA3, 1'b1, 1'b1, 1'b1);
    check_frame(8'hA3, 1'b1, 1'b1, 1'b1, -1, "a3_odd_s2");

    // Back-to-back with tx_valid held high
    @(negedge clk);
    par_en = 1'b0; par_odd = 1'b0; stop2 = 1'b0;
    bus.tx_data = 8'h00;
    bus.tx_valid = 1'b1;
    @(posedge clk);
    #1 bus.tx_data = 8'hFF;
    check_frame(8'h00, 1'b0, 1'b0, 1'b0, -1, "b2b_first");
    @(negedge clk);
    chk("b2b ready_one_cycle", {bus.tx_ready, tx_busy}, 2'b01);
    bus.tx_valid = 1'b0;
    check_frame(8'hFF, 1'b0, 1'b0, 1'b0, 15, "b2b_second");

    // Busy ignore: valid pulse and config change mid-frame
    send(8'hC4, 1'b1, 1'b0, 1'b0);
    fork
      check_frame(8'hC4, 1'b1, 1'b0, 1'b0, -1, "busy_ignore");
      begin
        repeat (50) @(negedge clk);
        bus.tx_data = 8'h12;
        par_odd = 1'b1; stop2 = 1'b1; par_en = 1'b0;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
      end
    join
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if ({txd, bus.tx_ready, tx_busy, tx_done} !== 4'b1100) bad++;
    end
    chk("busy_ignore idle_after", bad, 0);

    // Acceptance in the tick cycle: start waits for the following tick
    @(posedge uclk);
    par_en = 1'b0; par_odd = 1'b0; stop2 = 1'b0;
    bus.tx_data = 8'h96;
    bus.tx_valid = 1'b1;
    @(posedge clk);
    #1 bus.tx_valid = 1'b0;
    check_frame(8'h96, 1'b0, 1'b0, 1'b0, 17, "tick_collide");

    // Reset during data bit 3
    send(8'hA5, 1'b0, 1'b0, 1'b0);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (txd !== 1'b0 && w < 400);
    repeat (BIT_CLKS * 4 + 8) @(negedge clk);
    chk("midrst pre_txd_bit3", txd, 1'b0);
    #3 rst = 1'b1;
    #1 chk("midrst async{txd,ready,busy,done}", {txd, bus.tx_ready, tx_busy, tx_done}, 4'b1100);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    send(8'h3C, 1'b0, 1'b0, 1'b0);
    check_frame(8'h3C, 1'b0, 1'b0, 1'b0, -1, "after_rst_3c");

    // Random frames
    for (int k = 0; k < 5; k++) begin
      rd  = 8'($urandom);
      rpe = 1'($urandom);
      rpo = 1'($urandom);
      rs2 = 1'($urandom);
      repeat ($urandom_range(0, 20)) @(negedge clk);
      send(rd, rpe, rpo, rs2);
      check_frame(rd, rpe, rpo, rs2, -1, $sformatf("rand%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
